// File: rtl/tx_framer_pkg.sv
// tx_framer_pkg: shared states, magic words, register offsets and flag bits for the TX packet framer
package tx_framer_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3
`ifdef TX_FRAMER_PAD_EN
    ,S_PAD    = 3'd4
`endif
  } state_t;
  localparam logic [15:0] HDR_MAGIC  = 16'hdead;
  localparam logic [15:0] CTRL_MAGIC = 16'hcafe;
  localparam logic [7:0] SR_LEN   = 8'd0;
  localparam logic [7:0] SR_FLAGS = 8'd1;
  localparam logic [7:0] SR_CTRL  = 8'd2;
  localparam int FLAG_SOP = 0;
  localparam int FLAG_EOP = 1;
endpackage

// File: rtl/framer_setting_regs.sv
// framer_setting_regs: settings-bus decode for packet length, header flags and enable
module framer_setting_regs
  import tx_framer_pkg::*;
#(
  parameter logic [7:0] SR_BASE = 8'd160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [15:0] len_reg,
  output logic [2:0]  flag_reg,
  output logic        enable
);
  logic unused_bits;
  assign unused_bits = ^set_data[31:16];
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg  <= '0;
      flag_reg <= '0;
      enable   <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == SR_BASE + SR_LEN) len_reg <= set_data[15:0];
      if (set_addr == SR_BASE + SR_FLAGS) flag_reg <= set_data[2:0];
      if (set_addr == SR_BASE + SR_CTRL) enable <= set_data[0];
    end
  end
endmodule

// File: rtl/tx_packet_framer.sv
// tx_packet_framer: wraps a 32-bit sample stream into 0xdead/0xcafe-headed packets of programmed length.
// Define TX_FRAMER_PAD_EN to zero-pad a packet once the source stalls PAD_TIMEOUT cycles mid-payload.
module tx_packet_framer
  import tx_framer_pkg::*;
#(
  parameter logic [7:0] SR_BASE     = 8'd160,
  parameter int         PAD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] in_dat_i,
  input  logic        in_ready_i,
  output logic        in_ready_o,
  output logic [31:0] out_dat_o,
  output logic [3:0]  out_flags_o,
  output logic        out_ready_o,
  input  logic        out_ready_i,
  output logic [15:0] pkt_count,
  output logic        busy,
  output logic [31:0] debug
);
  logic [15:0] len_reg, len_cur, remaining;
  logic [2:0]  flag_reg, flag_cur;
  logic        enable, last, out_xfer, pad_active, data_st;
  state_t      state, nxt;

  framer_setting_regs #(.SR_BASE(SR_BASE)) regs (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .len_reg(len_reg), .flag_reg(flag_reg), .enable(enable)
  );

  assign last     = remaining == 16'd1;
  assign out_xfer = out_ready_o & out_ready_i;
  assign data_st  = (state == S_PAYLOAD) || pad_active;
  assign busy     = state != S_IDLE;
  assign debug    = {24'b0, pad_active, in_ready_i, out_ready_i, out_ready_o, 1'b0, state};

`ifdef TX_FRAMER_PAD_EN
  logic [15:0] stall;
  logic        stalled;
  assign pad_active = state == S_PAD;
  assign stalled    = stall >= 16'(PAD_TIMEOUT);
  // Counts source-idle cycles; any accepted sample restarts the timeout.
  always_ff @(posedge clk) begin
    if (rst || state != S_PAYLOAD || (in_ready_i && out_ready_i)) stall <= '0;
    else if (!in_ready_i) stall <= stall + 16'd1;
  end
`else
  logic unused_pad;
  assign pad_active = 1'b0;
  assign unused_pad = PAD_TIMEOUT[0];
`endif

  always_comb begin
    nxt         = state;
    out_dat_o   = '0;
    out_flags_o = '0;
    out_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    case (state)
      S_IDLE: nxt = (enable && len_reg != '0 && in_ready_i) ? S_HDR0 : S_IDLE;
      S_HDR0: begin
        out_dat_o             = {HDR_MAGIC, 13'b0, flag_cur};
        out_flags_o[FLAG_SOP] = 1'b1;
        out_ready_o           = 1'b1;
        nxt                   = out_ready_i ? S_HDR1 : S_HDR0;
      end
      S_HDR1: begin
        out_dat_o   = {CTRL_MAGIC, len_cur};
        out_ready_o = 1'b1;
        nxt         = out_ready_i ? S_PAYLOAD : S_HDR1;
      end
      S_PAYLOAD: begin
        out_dat_o             = in_dat_i;
        out_ready_o           = in_ready_i;
        in_ready_o            = out_ready_i;
        out_flags_o[FLAG_EOP] = last;
        nxt                   = (in_ready_i && out_ready_i && last) ? S_IDLE : S_PAYLOAD;
`ifdef TX_FRAMER_PAD_EN
        if (!(in_ready_i && out_ready_i) && stalled) nxt = S_PAD;
`endif
      end
`ifdef TX_FRAMER_PAD_EN
      S_PAD: begin
        out_ready_o           = 1'b1;
        out_flags_o[FLAG_EOP] = last;
        nxt                   = (out_ready_i && last) ? S_IDLE : S_PAD;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_cur   <= '0;
      flag_cur  <= '0;
      remaining <= '0;
      pkt_count <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && nxt == S_HDR0) begin
        len_cur  <= len_reg;
        flag_cur <= flag_reg;
      end
      if (state == S_HDR1 && out_ready_i) remaining <= len_cur;
      else if (data_st && out_xfer) remaining <= remaining - 16'd1;
      if (data_st && out_xfer && last) pkt_count <= pkt_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_tx_packet_framer.sv
// tb_tx_packet_framer: randomized scoreboard bench; expected packets are built from the framing rules
module tb_tx_packet_framer;
  logic        clk = 1'b0, rst = 1'b1, set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0, in_dat_i = '0;
  logic        in_ready_i = 1'b0, out_ready_i = 1'b1;
  logic        in_ready_o, out_ready_o, busy;
  logic [31:0] out_dat_o, debug;
  logic [3:0]  out_flags_o;
  logic [15:0] pkt_count;

  tx_packet_framer dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_dat_i(in_dat_i), .in_ready_i(in_ready_i), .in_ready_o(in_ready_o),
    .out_dat_o(out_dat_o), .out_flags_o(out_flags_o), .out_ready_o(out_ready_o),
    .out_ready_i(out_ready_i), .pkt_count(pkt_count), .busy(busy), .debug(debug)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  f;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] src[$], mdl[$];
  int          tests = 0, fails = 0, exp_pkts = 0, nout = 0;
  int          sink_mode = 0, src_mode = 0;
  logic        ix, hold_v = 1'b0;
  logic [31:0] hold_d;
  word_t       w;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on every accepted output word, plus header-hold check under backpressure.
  always @(negedge clk) begin
    if (hold_v) begin
      check("hdr_hold_valid", {31'b0, out_ready_o}, 32'd1);
      check("hdr_hold_data", out_dat_o, hold_d);
    end
    hold_v = !rst && out_ready_o && !out_ready_i && (debug[2:0] == 3'd1 || debug[2:0] == 3'd2);
    hold_d = out_dat_o;
    if (!rst && out_ready_o) nout++;
    if (!rst && out_ready_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", out_dat_o);
      end else begin
        w = exp_q.pop_front();
        check("word_data", out_dat_o, w.d);
        check("word_flags", {28'b0, out_flags_o}, {28'b0, w.f});
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready_i = sink_mode == 0 ? 1'b1 : sink_mode == 1 ? ~out_ready_i : 1'($urandom_range(1));
  end

  initial forever begin
    @(negedge clk);
    ix = in_ready_i & in_ready_o & !rst;
    @(posedge clk);
    #1;
    if (ix && src.size() != 0) void'(src.pop_front());
    in_ready_i = src.size() != 0 && (src_mode == 0 || $urandom_range(3) != 0);
    in_dat_i   = src.size() != 0 ? src[0] : $urandom;
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #2;
    set_stb = 1'b0;
  endtask

  task automatic load(input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      src.push_back(v);
      mdl.push_back(v);
    end
  endtask

  // A packet: header, control word, then len words of which the first avail come from the source, the rest are zero.
  task automatic push_pkt(input int len, input logic [2:0] fl, input int avail);
    exp_q.push_back({{16'hdead, 13'b0, fl}, 4'b0001});
    exp_q.push_back({{16'hcafe, 16'(len)}, 4'b0000});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i < avail ? mdl.pop_front() : 32'h0), (i == len - 1 ? 4'b0010 : 4'b0000)});
    exp_pkts++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (debug[2:0] != s && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (debug[2:0] != s) begin
      tests++;
      fails++;
      $display("FAIL wait_state: got %0d expected %0d", debug[2:0], s);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    src.delete();
    mdl.delete();
    exp_pkts = 0;
  endtask

  initial begin
    int n0, len;
    logic [2:0] fl;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_ready", {31'b0, out_ready_o}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pkt_count", {16'b0, pkt_count}, 32'd0);
    wr(8'd162, 32'd1);
    load(2);
    n0 = nout;
    repeat (100) @(posedge clk);
    #2;
    check("len0_no_output", nout, n0);
    check("len0_busy", {31'b0, busy}, 32'd0);
    check("len0_pkt_count", {16'b0, pkt_count}, 32'd0);
    push_pkt(2, 3'd0, 2);
    wr(8'd160, 32'd2);
    drain(200);
    check("len2_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    wr(8'd160, 32'd4);
    wr(8'd161, 32'd5);
    load(4);
    push_pkt(4, 3'd5, 4);
    drain(200);
    check("basic_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    sink_mode = 1;
    load(4);
    push_pkt(4, 3'd5, 4);
    drain(200);
    check("toggle_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    sink_mode = 2;
    load(12);
    push_pkt(4, 3'd5, 4);
    push_pkt(8, 3'd5, 8);
    wait_state(3'd3);
    wr(8'd160, 32'd8);
    drain(400);
    check("relen_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    wr(8'd160, 32'd6);
    load(9);
    push_pkt(6, 3'd5, 6);
    wait_state(3'd3);
    wr(8'd162, 32'd0);
    drain(400);
    n0 = nout;
    repeat (30) @(posedge clk);
    #2;
    check("disable_busy", {31'b0, busy}, 32'd0);
    check("disable_no_output", nout, n0);
    check("disable_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    src.delete();
    mdl.delete();
    sink_mode = 0;
    repeat (3) @(posedge clk);
    wr(8'd162, 32'd1);
    wr(8'd160, 32'd4);
    load(4);
    push_pkt(4, 3'd5, 4);
    n0 = 0;
    while (exp_q.size() > 2 && n0 < 200) begin
      @(posedge clk);
      #2;
      n0++;
    end
    check("pre_reset_words_left", exp_q.size(), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    src.delete();
    mdl.delete();
    exp_pkts = 0;
    @(negedge clk);
    check("midrst_out_ready", {31'b0, out_ready_o}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready_o}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_pkt_count", {16'b0, pkt_count}, 32'd0);
    wr(8'd160, 32'd4);
    wr(8'd161, 32'd2);
    wr(8'd162, 32'd1);
    load(4);
    push_pkt(4, 3'd2, 4);
    drain(200);
    check("fresh_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    wr(8'd160, 32'd10);
    load(3);
    push_pkt(10, 3'd2, 3);
`ifdef TX_FRAMER_PAD_EN
    drain(400);
    check("pad_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
`else
    repeat (300) @(posedge clk);
    #2;
    check("stall_words_left", exp_q.size(), 32'd7);
    check("stall_busy", {31'b0, busy}, 32'd1);
    check("stall_state", {29'b0, debug[2:0]}, 32'd3);
    check("stall_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts - 1));
    do_reset();
`endif
    wr(8'd162, 32'd1);
    src_mode  = 1;
    sink_mode = 2;
    repeat (8) begin
      len = $urandom_range(20, 1);
      fl  = 3'($urandom_range(7));
      wr(8'd160, 32'(len));
      wr(8'd161, {29'b0, fl});
      load(len);
      push_pkt(len, fl, len);
      drain(600);
      check("rand_pkt_count", {16'b0, pkt_count}, 32'(exp_pkts));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/tx_packet_framer.md
Name: tx_packet_framer

Overview:
- Upstream neighbour of the TX control stage; sits between the host-side sample source and the TX control input FIFO interface.
- Wraps a raw 32-bit sample stream into framed packets: header word 0xdead, control word 0xcafe, then N payload words, with EOP flagged on the last payload word.
- Packet length, header flags and enable are programmed over the settings bus.
- Gives the TX control stage a well-formed packet stream, so it never needs to resynchronise on a stray header.

Parameters:
- SR_BASE, 8'd160, settings-bus base address; registers at SR_BASE+0, SR_BASE+1, SR_BASE+2.
- PAD_TIMEOUT, 64, idle cycles mid-payload before padding starts (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- in_dat_i  in  32  sample from source
- in_ready_i  in  1  source has a valid sample
- in_ready_o  out  1  framer accepts the sample this cycle
- out_dat_o  out  32  framed word to TX control
- out_flags_o  out  4  bit0 SOP, bit1 EOP, bits[3:2] occupancy (always 0)
- out_ready_o  out  1  framed word valid
- out_ready_i  in  1  TX control accepts the word
- pkt_count  out  16  packets completed (EOP accepted), wraps at 0xFFFF→0
- busy  out  1  packet in progress (state != IDLE)
- debug  out  32  {24'b0, pad_active, in_ready_i, out_ready_i, out_ready_o, 1'b0, state[2:0]}

Behaviour:
- Transfers: output transfer = out_ready_o & out_ready_i; input transfer = in_ready_i & in_ready_o.
- Settings registers:
  - SR_BASE+0: len_reg[15:0].
  - SR_BASE+1: flag_reg[2:0].
  - SR_BASE+2: bit0 enable.
  - Reset values: all 0.
- Snapshot: len_reg and flag_reg are latched into len_cur and flag_cur on the IDLE→HDR0 transition. Register writes mid-packet affect only the next packet.
- States: IDLE(0), HDR0(1), HDR1(2), PAYLOAD(3), PAD(4).
- IDLE:
  - out_ready_o=0, in_ready_o=0.
  - Go to HDR0 when enable & len_reg!=0 & in_ready_i. No header is opened without data present.
- HDR0:
  - out_dat_o={16'hdead,13'b0,flag_cur}, out_flags_o=4'b0001, out_ready_o=1.
  - On output transfer go to HDR1.
- HDR1:
  - out_dat_o={16'hcafe,len_cur}, flags=0, out_ready_o=1.
  - On output transfer go to PAYLOAD; remaining counter is loaded with len_cur.
- PAYLOAD (combinational pass-through, zero latency):
  - out_dat_o=in_dat_i, out_ready_o=in_ready_i, in_ready_o=out_ready_i.
  - Flags bit1 (EOP) = (remaining==1).
  - Each transfer decrements remaining. Transfer with remaining==1 → IDLE and pkt_count+1.
- Header stability: in HDR0/HDR1 the header words and out_ready_o stay constant until accepted; backpressure of any length is legal.
- Enable cleared mid-packet: the current packet completes normally; the block then stays in IDLE.
- len_reg=0: no packets are framed.
- Width: len_cur and remaining are 16 bits; maximum payload 65535 words.
- Reset mid-packet:
  - State→IDLE; counters, registers and pkt_count→0.
  - Outputs next cycle: out_ready_o=0, in_ready_o=0, busy=0.
  - Downstream sees a truncated packet, which its XFER state machine tolerates.
- Simultaneous set_stb and packet start: the snapshot takes the pre-write register value.

Optional Feature:
- Macro: TX_FRAMER_PAD_EN.
- With the macro defined:
  - In PAYLOAD, a 16-bit stall counter counts cycles with in_ready_i=0 and resets on any input transfer.
  - When the counter reaches PAD_TIMEOUT, go to PAD. PAD emits 32'h0 with out_ready_o=1 and in_ready_o=0, decrements remaining per output transfer, and asserts EOP on the last word. After that word → IDLE, pkt_count+1.
  - pad_active is 1 in PAD.
  - This prevents an underrun in the TX control stage when the source stalls.
- Without the macro: PAD state, stall counter and pad_active are absent (debug bit forced to 0), and PAYLOAD waits indefinitely.

Decomposition:
- Shared package tx_framer_pkg:
  - State encodings.
  - HDR_MAGIC=16'hdead and CTRL_MAGIC=16'hcafe.
  - Register offsets SR_LEN=0, SR_FLAGS=1, SR_CTRL=2.
  - Flag bit positions FLAG_SOP=0 and FLAG_EOP=1.
- One sub-module, framer_setting_regs: decodes the settings bus and holds len_reg, flag_reg and enable.

Test Plan:
- len=4, flags=3'b101, enable=1, source always valid, sink always ready → words 0xdead0005, 0xcafe0004, s0..s3; SOP on word0 only, EOP on s3 only; pkt_count=1.
- Same setup with out_ready_i toggling 1-0 every cycle → identical word sequence, each header held stable while not ready, no word lost or duplicated.
- Write len=8 while the payload of a len=4 packet is in progress → current packet ends after 4 words; next header is 0xcafe0008.
- len=0 with enable=1 and source valid for 100 cycles → out_ready_o stays 0, pkt_count=0; enable=0 mid-packet → packet completes, then block idles.
- Assert rst after 2 of 4 payload words → next cycle out_ready_o=0, busy=0, pkt_count=0; a fresh packet starts from HDR0 after reconfiguration.
- With TX_FRAMER_PAD_EN, PAD_TIMEOUT=64, len=10: source stalls after 3 samples → after 64 idle cycles, 7 zero words are emitted, last with EOP; pkt_count=1. Without the macro, the block stays in PAYLOAD.
